snail_pattern_tx: RTL
=====================

// Module: snail_pattern_tx
// PURPOSE
//  Transmit-side counterpart of the snail pattern recognizers: serializes parallel words onto a 1-bit line.
//  Each frame carries a "0->1" marker that a Moore/Mealy "01" recognizer at the far end fires on.
//  Sits between a word producer (valid/ready) and the serial link; the idle line is held high so a
//  recognizer never fires between frames.
// PARAMETERS
//  DATA_W    8  payload bits per frame (>=1)
//  SYNC_LEN  2  number of 0 bits preceding the marker 1 (>=1)
// PORTS
//  clk         in   1       clock, rising edge
//  reset       in   1       asynchronous, active-high
//  in_valid    in   1       producer has a word on in_data
//  in_data     in   DATA_W  payload word
//  in_ready    out  1       block accepts in_data this cycle
//  tx_out      out  1       serial line, registered
//  busy        out  1       frame in progress (state != IDLE)
//  frame_done  out  1       one-cycle pulse during the STOP bit
// BEHAVIOUR
//  Clock and reset: clk; reset is asynchronous, active-high.
//  Reset values: state=IDLE, tx_out=1, busy=0, frame_done=0, bit counter=0, shift register=0.
//    in_ready=1 from reset release onward.
//  Handshake:
//    - Transfer occurs when in_valid & in_ready at a clk edge; in_data is latched into the shift register.
//    - in_ready = (state==IDLE) | (state==STOP); it is combinational from state only, never from in_valid.
//  Frame on tx_out: SYNC_LEN x 0, then 1 marker bit, then DATA_W bits MSB-first, [parity], then 1 stop bit (=1).
//    Each bit is held exactly one cycle.
//  Latency: the first SYNC bit appears on tx_out the cycle after the transfer edge.
//  FSM states:
//    IDLE -> SYNC on transfer; otherwise stays in IDLE with tx_out=1.
//    SYNC -> MARK after SYNC_LEN cycles, using the bit counter.
//    MARK -> DATA after 1 cycle.
//    DATA -> PARITY (if enabled) or STOP after DATA_W cycles; the shift register shifts left each cycle.
//    PARITY -> STOP after 1 cycle.
//    STOP -> SYNC on transfer (back-to-back frames with no idle gap); otherwise -> IDLE.
//  Frame length = SYNC_LEN + 1 + DATA_W + P + 1 cycles, where P=1 with parity, else 0.
//  The bit counter is $clog2(max(SYNC_LEN,DATA_W)+1) bits wide. It is cleared on every state change and never wraps.
//  frame_done=1 exactly in the STOP cycle, including when a new word is accepted in that same cycle.
//  in_valid while busy (outside STOP) is ignored; in_data may change freely and has no effect on the frame in flight.
//  Reset mid-frame: the frame is aborted immediately. tx_out returns to 1 asynchronously and no partial frame resumes.
//  An undefined state encoding recovers to IDLE.
// CONFIGURATION
//  SNAIL_PATTERN_TX_PARITY_EN defined:
//    - a PARITY state emits even parity (XOR of the DATA_W payload bits) between DATA and STOP.
//    - frame length grows by 1 cycle.
//  Not defined: no PARITY state; DATA goes directly to STOP.
// STRUCTURE
//  Shared package snail_pattern_pkg holds:
//    - typedef enum logic[2:0] {IDLE, SYNC, MARK, DATA, PARITY, STOP} tx_state_t
//    - localparam IDLE_LEVEL = 1'b1
//    - MARK_PATTERN = 2'b01, shared with the recognizers
//  One sub-module: snail_shift_out, a DATA_W-bit load/shift-left register with MSB output.
//    It is reused by future serializers.
//  The FSM, counter and handshake stay in the top module.
// TESTING
//  1. Reset release with in_valid=0 for 10 cycles -> tx_out=1, busy=0, in_ready=1, frame_done never asserted.
//  2. DATA_W=8, SYNC_LEN=2, send 8'hA5 (no parity)
//     -> tx_out = 0,0,1,1,0,1,0,0,1,0,1,1 over 12 cycles, then idle 1; frame_done in cycle 12.
//  3. Back-to-back: in_valid held high with 8'h00 then 8'hFF
//     -> second SYNC starts the cycle after the first STOP; no idle cycle; two frame_done pulses 12 cycles apart.
//  4. Line fed to the Moore and Mealy "01" recognizers for the 8'hA5 frame
//     -> the first recognizer hit aligns with the MARK bit; no hits while idle.
//  5. Assert reset during DATA bit 3 of 8'hC3 -> tx_out=1 and busy=0 immediately; the next frame sent is complete and correct.
//  6. With SNAIL_PATTERN_TX_PARITY_EN, send 8'h07
//     -> parity bit 1 after the data bits; 13-cycle frame; 8'h03 gives parity 0.

Source files
------------

// File: rtl/snail_pattern_pkg.sv
// Shared definitions for the snail pattern transmitter and the "01" recognizers.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: tx_state_t FSM encoding, IDLE_LEVEL line level, MARK_PATTERN frame marker.
package snail_pattern_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SYNC,
    MARK,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  // Level held on the line between frames; a "01" recognizer never fires on it.
  localparam logic IDLE_LEVEL = 1'b1;

  // Marker the recognizers look for: [1] is the sync level, [0] the marker bit.
  localparam logic [1:0] MARK_PATTERN = 2'b01;

endpackage

// File: rtl/snail_shift_out.sv
// Load / shift-left register presenting its MSB, for MSB-first serializers.
// Latency: load and shift take effect at the next clk edge; msb_o is the registered MSB.
// Backpressure: none; the owner decides when to load or shift (load wins).
// Ports: clk, reset (async, active-high), load_i/data_i parallel load,
//        shift_i shift left by one with zero fill, msb_o current MSB.
module snail_shift_out #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load_i,
  input  logic         shift_i,
  input  logic [W-1:0] data_i,
  output logic         msb_o
);

  logic [W-1:0] sr_q;
  logic [W-1:0] sr_d;

  always_comb begin
    sr_d = sr_q;
    if (load_i) begin
      sr_d = data_i;
    end else if (shift_i) begin
      sr_d = sr_q << 1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign msb_o = sr_q[W-1];

endmodule

// File: rtl/snail_pattern_tx.sv
// Serializes parallel words into framed bits: SYNC_LEN x 0, marker 1, payload MSB-first, [parity], stop 1.
// Latency: first sync bit on tx_out the cycle after the accepting edge; frame is
//          SYNC_LEN+1+DATA_W+P+1 cycles. Backpressure: in_ready only in IDLE or STOP (back-to-back frames).
// Ports: clk, reset (async, active-high); in_valid/in_data/in_ready word input;
//        tx_out registered serial line; busy (state != IDLE); frame_done pulse in the STOP cycle.
// Optional feature: define SNAIL_PATTERN_TX_PARITY_EN to add an even-parity bit before STOP.
module snail_pattern_tx
  import snail_pattern_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int SYNC_LEN = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              tx_out,
  output logic              busy,
  output logic              frame_done
);

  localparam int MAX_LEN = (SYNC_LEN > DATA_W) ? SYNC_LEN : DATA_W;
  localparam int CNT_W   = $clog2(MAX_LEN + 1);
  localparam logic [CNT_W-1:0] SYNC_LAST = CNT_W'(SYNC_LEN - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);

  tx_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tx_out_q, tx_out_d;
  logic             xfer;
  logic             shift_en;
  logic             shift_msb;

`ifdef SNAIL_PATTERN_TX_PARITY_EN
  logic             parity_q;
`endif

  assign in_ready   = (state_q == IDLE) || (state_q == STOP);
  assign xfer       = in_valid & in_ready;
  assign busy       = (state_q != IDLE);
  assign frame_done = (state_q == STOP);
  assign tx_out     = tx_out_q;

  // Next-state logic and bit counter.
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    case (state_q)
      IDLE: if (xfer) state_d = SYNC;
      SYNC: if (cnt_q == SYNC_LAST) state_d = MARK;
      MARK: state_d = DATA;
      DATA: begin
        if (cnt_q == DATA_LAST) begin
`ifdef SNAIL_PATTERN_TX_PARITY_EN
          state_d = PARITY;
`else
          state_d = STOP;
`endif
        end
      end
`ifdef SNAIL_PATTERN_TX_PARITY_EN
      PARITY: state_d = STOP;
`endif
      STOP: state_d = xfer ? SYNC : IDLE;
      default: state_d = IDLE;
    endcase

    // Counter only runs in the multi-cycle states and restarts on any state change,
    // so it tops out at SYNC_LEN-1 / DATA_W-1 and never wraps.
    if ((state_d == state_q) && ((state_q == SYNC) || (state_q == DATA))) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // The shifter presents the bit for the DATA cycle being entered and advances at
  // that same edge, so the next DATA cycle sees the following bit on its MSB.
  assign shift_en = (state_d == DATA);

  // tx_out is registered from the state being entered, which puts the first sync
  // bit on the line the cycle after the accepting edge.
  always_comb begin
    tx_out_d = IDLE_LEVEL;
    case (state_d)
      SYNC:   tx_out_d = MARK_PATTERN[1];
      MARK:   tx_out_d = MARK_PATTERN[0];
      DATA:   tx_out_d = shift_msb;
`ifdef SNAIL_PATTERN_TX_PARITY_EN
      PARITY: tx_out_d = parity_q;
`endif
      default: tx_out_d = IDLE_LEVEL;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      tx_out_q <= IDLE_LEVEL;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      tx_out_q <= tx_out_d;
    end
  end

`ifdef SNAIL_PATTERN_TX_PARITY_EN
  // Even parity of the whole payload, captured with the word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      parity_q <= 1'b0;
    end else if (xfer) begin
      parity_q <= ^in_data;
    end
  end
`endif

  snail_shift_out #(
    .W (DATA_W)
  ) u_shift (
    .clk     (clk),
    .reset   (reset),
    .load_i  (xfer),
    .shift_i (shift_en),
    .data_i  (in_data),
    .msb_o   (shift_msb)
  );

endmodule
